mci_mcu_sram_arb: RTL and testbench

//  Two-requester arbiter in front of the MCU SRAM controller's SRAM port. Shares the single-ported MCU SRAM

---
 rtl/mci_mcu_sram_arb_pkg.sv | 22 ++
 rtl/mci_mcu_sram_arb_rr_arb2.sv | 31 +++
 rtl/mci_mcu_sram_arb.sv | 112 +++++++++++
 tb/tb_mci_mcu_sram_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mci_mcu_sram_arb_pkg.sv
// Shared types and constants for the MCU SRAM two-requester arbiter.
package mci_mcu_sram_arb_pkg;

    localparam int MCU_SRAM_ARB_NUM_REQ = 2;

    // Request fields of whichever requester won arbitration this cycle.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mcu_sram_arb_req_t;

    // One slot of the response pipe: who issued it, what kind, and whether it was out of range.
    typedef struct packed {
        logic vld;
        logic owner;
        logic write;
        logic err;
    } mcu_sram_arb_rsp_tag_t;

endpackage

// File: rtl/mci_mcu_sram_arb_rr_arb2.sv
// Two-way round-robin arbiter. The pointer only moves when both requesters compete,
// and then it points at the requester that lost.
module mci_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       win
);

    logic rr_ptr;

    // Pick the sole requester, or the one rr_ptr favours when both are asking.
    always_comb begin
        grant = 2'b00;
        win   = (req == 2'b11) ? rr_ptr : req[1];
        if (req != 2'b00) begin
            grant[win] = 1'b1;
        end
    end

    // Flip priority away from the winner after every contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (req == 2'b11) begin
            rr_ptr <= ~win;
        end
    end

endmodule

// File: rtl/mci_mcu_sram_arb.sv
// Arbiter sharing the single-ported MCU SRAM between the MCU LSU/IFU path (requester 0)
// and the Caliptra/AXI CIF path (requester 1). One access per cycle, responses returned
// in order after a fixed latency. Requester addresses may be at most 32 bits wide.
module mci_mcu_sram_arb
    import mci_mcu_sram_arb_pkg::*;
#(
    parameter int MCU_SRAM_SIZE_KB = 1024,
    parameter int ADDR_W           = $clog2(MCU_SRAM_SIZE_KB * 1024 / 4),
    parameter int REQ_ADDR_W       = 32,
    parameter int RD_LAT           = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 req_dv,
    input  logic [1:0]                 req_write,
    input  logic [1:0][REQ_ADDR_W-1:0] req_addr,
    input  logic [1:0][31:0]           req_wdata,
    input  logic [1:0][3:0]            req_wstrb,
    output logic [1:0]                 req_hold,
    output logic [1:0]                 rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic [1:0]                 rsp_error,
    output logic                       sram_cs,
    output logic                       sram_we,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [31:0]                sram_wdata,
    output logic [3:0]                 sram_wstrb,
    input  logic [31:0]                sram_rdata
);

    localparam int DEPTH = MCU_SRAM_SIZE_KB * 1024 / 4;

    logic [1:0]            req_live;
    logic [1:0]            grant;
    logic                  win;
    logic                  any_gnt;
    logic                  in_range;
    logic [1:0]            unused_addr_lsb;
    mcu_sram_arb_req_t     sel;
    mcu_sram_arb_rsp_tag_t new_tag;
    mcu_sram_arb_rsp_tag_t out_tag;
    mcu_sram_arb_rsp_tag_t pipe [RD_LAT];

    // Nobody is granted while reset is asserted.
    assign req_live = req_dv & {2{~rst}};

    mci_rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req   (req_live),
        .grant (grant),
        .win   (win)
    );

    // Mux the winning requester's fields and check the dword index against the SRAM depth.
    always_comb begin
        sel.write       = req_write[win];
        sel.addr        = 32'(req_addr[win]);
        sel.wdata       = req_wdata[win];
        sel.wstrb       = req_wstrb[win];
        any_gnt         = |grant;
        in_range        = sel.addr[31:2] < 30'(DEPTH);
        unused_addr_lsb = sel.addr[1:0];
    end

    // Drive the SRAM port and handshakes; out-of-range requests are accepted without touching the SRAM.
    always_comb begin
        req_hold   = rst ? 2'b11 : (req_dv & ~grant);
        sram_cs    = any_gnt & in_range;
        sram_we    = sram_cs & sel.write;
        sram_addr  = sram_cs ? sel.addr[ADDR_W+1:2] : '0;
        sram_wdata = sram_we ? sel.wdata : 32'h0;
        sram_wstrb = sram_we ? sel.wstrb : 4'h0;
        new_tag    = '0;
        if (any_gnt) begin
            new_tag.vld   = 1'b1;
            new_tag.owner = win;
            new_tag.write = sel.write;
            new_tag.err   = ~in_range;
        end
    end

    // Carry each accepted request's tag alongside the SRAM read latency; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= new_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Route the oldest tag to its owner; only clean reads carry SRAM data.
    always_comb begin
        out_tag   = pipe[RD_LAT-1];
        rsp_valid = 2'b00;
        rsp_error = 2'b00;
        rsp_rdata = 32'h0;
        if (!rst && out_tag.vld) begin
            rsp_valid[out_tag.owner] = 1'b1;
            rsp_error[out_tag.owner] = out_tag.err;
            if (!out_tag.write && !out_tag.err) begin
                rsp_rdata = sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mci_mcu_sram_arb.sv
// Directed bench for mci_mcu_sram_arb with a behavioural SRAM model behind it.
module tb_mci_mcu_sram_arb;

    localparam int RD_LAT = 2;
    localparam int ADDR_W = 18;
    localparam int NVEC   = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_dv = '0;
    logic [1:0]        req_write = '0;
    logic [1:0][31:0]  req_addr = '0;
    logic [1:0][31:0]  req_wdata = '0;
    logic [1:0][3:0]   req_wstrb = '0;
    logic [1:0]        req_hold;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_error;
    logic              sram_cs;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [3:0]        sram_wstrb;
    logic [31:0]       sram_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]        dv;
        logic [1:0]        wr;
        logic [31:0]       a0;
        logic [31:0]       a1;
        logic [31:0]       d0;
        logic [31:0]       d1;
        logic [3:0]        s0;
        logic [3:0]        s1;
        logic [1:0]        e_hold;
        logic              e_cs;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       e_wdata;
        logic [3:0]        e_wstrb;
        logic [1:0]        e_rv;
        logic [31:0]       e_rd;
        logic [1:0]        e_re;
    } vec_t;

    vec_t vecs [NVEC];

    mci_mcu_sram_arb #(
        .MCU_SRAM_SIZE_KB (1024),
        .ADDR_W           (ADDR_W),
        .REQ_ADDR_W       (32),
        .RD_LAT           (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_dv     (req_dv),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_hold   (req_hold),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_wstrb (sram_wstrb),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Sparse SRAM model: byte-masked writes, read data appears RD_LAT cycles after the read.
    logic [31:0] mem [int];
    logic [31:0] rpipe [RD_LAT];

    initial begin
        for (int i = 0; i < RD_LAT; i++) rpipe[i] = 32'h0;
    end

    assign sram_rdata = rpipe[RD_LAT-1];

    always @(posedge clk) begin
        logic [31:0] cur;
        cur = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)] : 32'h0;
        rpipe[0] <= (sram_cs && !sram_we) ? cur : 32'h0;
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (sram_cs && sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wstrb[b]) cur[8*b +: 8] = sram_wdata[8*b +: 8];
            end
            mem[int'(sram_addr)] = cur;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(posedge clk);
        #1;
        req_dv       = v.dv;
        req_write    = v.wr;
        req_addr[0]  = v.a0;
        req_addr[1]  = v.a1;
        req_wdata[0] = v.d0;
        req_wdata[1] = v.d1;
        req_wstrb[0] = v.s0;
        req_wstrb[1] = v.s1;
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        req_dv    = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    initial begin
        int cnt0;
        int cnt1;
        logic [1:0] exp_rv;

        // Directed vectors; rr_ptr starts at 0 and only v8/v9/v10 are contested.
        vecs[0]  = '{2'b01, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0,
                     2'b00, 1'b1, 1'b1, 18'h4, 32'hDEADBEEF, 4'hF, 2'b01, 32'h0, 2'b00};
        vecs[1]  = '{2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b00, 1'b1, 1'b0, 18'h4, 32'h0, 4'h0, 2'b01, 32'hDEADBEEF, 2'b00};
        vecs[2]  = '{2'b01, 2'b01, 32'h20, 32'h0, 32'hFFFFFFFF, 32'h0, 4'hF, 4'h0,
                     2'b00, 1'b1, 1'b1, 18'h8, 32'hFFFFFFFF, 4'hF, 2'b01, 32'h0, 2'b00};
        vecs[3]  = '{2'b01, 2'b01, 32'h20, 32'h0, 32'h11223344, 32'h0, 4'h5, 4'h0,
                     2'b00, 1'b1, 1'b1, 18'h8, 32'h11223344, 4'h5, 2'b01, 32'h0, 2'b00};
        vecs[4]  = '{2'b01, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b00, 1'b1, 1'b0, 18'h8, 32'h0, 4'h0, 2'b01, 32'hFF22FF44, 2'b00};
        vecs[5]  = '{2'b10, 2'b00, 32'h0, 32'h00100000, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b00, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 2'b10, 32'h0, 2'b10};
        vecs[6]  = '{2'b01, 2'b01, 32'h20, 32'h0, 32'hCAFEF00D, 32'h0, 4'h0, 4'h0,
                     2'b00, 1'b1, 1'b1, 18'h8, 32'hCAFEF00D, 4'h0, 2'b01, 32'h0, 2'b00};
        vecs[7]  = '{2'b10, 2'b00, 32'h0, 32'h20, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b00, 1'b1, 1'b0, 18'h8, 32'h0, 4'h0, 2'b10, 32'hFF22FF44, 2'b00};
        vecs[8]  = '{2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b10, 1'b1, 1'b0, 18'h4, 32'h0, 4'h0, 2'b01, 32'hDEADBEEF, 2'b00};
        vecs[9]  = '{2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b01, 1'b1, 1'b0, 18'h8, 32'h0, 4'h0, 2'b10, 32'hFF22FF44, 2'b00};
        vecs[10] = '{2'b11, 2'b01, 32'h30, 32'hFFFFC, 32'h55AA55AA, 32'h0, 4'hF, 4'h0,
                     2'b10, 1'b1, 1'b1, 18'hC, 32'h55AA55AA, 4'hF, 2'b01, 32'h0, 2'b00};
        vecs[11] = '{2'b10, 2'b00, 32'h0, 32'hFFFFC, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b00, 1'b1, 1'b0, 18'h3FFFF, 32'h0, 4'h0, 2'b10, 32'h0, 2'b00};
        vecs[12] = '{2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0,
                     2'b00, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0, 2'b00, 32'h0, 2'b00};
        vecs[13] = vecs[12];

        // Reset held for three cycles.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output($sformatf("reset hold c%0d", c), 32'(req_hold), 32'h3);
            check_output($sformatf("reset cs c%0d", c), 32'(sram_cs), 32'h0);
            check_output($sformatf("reset rsp_valid c%0d", c), 32'(rsp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_output($sformatf("idle hold c%0d", c), 32'(req_hold), 32'h0);
            check_output($sformatf("idle cs c%0d", c), 32'(sram_cs), 32'h0);
            check_output($sformatf("idle we c%0d", c), 32'(sram_we), 32'h0);
            check_output($sformatf("idle addr c%0d", c), 32'(sram_addr), 32'h0);
            check_output($sformatf("idle rsp c%0d", c), {rsp_rdata[29:0], rsp_valid}, 32'h0);
            check_output($sformatf("idle err c%0d", c), 32'(rsp_error), 32'h0);
        end

        // Table: grant-cycle outputs, plus the response owed by the vector RD_LAT steps earlier.
        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output($sformatf("v%0d hold", i), 32'(req_hold), 32'(vecs[i].e_hold));
            check_output($sformatf("v%0d cs", i), 32'(sram_cs), 32'(vecs[i].e_cs));
            if (vecs[i].e_cs) begin
                check_output($sformatf("v%0d we", i), 32'(sram_we), 32'(vecs[i].e_we));
                check_output($sformatf("v%0d addr", i), 32'(sram_addr), 32'(vecs[i].e_addr));
                check_output($sformatf("v%0d wdata", i), sram_wdata, vecs[i].e_wdata);
                check_output($sformatf("v%0d wstrb", i), 32'(sram_wstrb), 32'(vecs[i].e_wstrb));
            end
            if (i >= RD_LAT) begin
                check_output($sformatf("v%0d rsp_valid", i - RD_LAT), 32'(rsp_valid), 32'(vecs[i-RD_LAT].e_rv));
                check_output($sformatf("v%0d rsp_rdata", i - RD_LAT), rsp_rdata, vecs[i-RD_LAT].e_rd);
                check_output($sformatf("v%0d rsp_error", i - RD_LAT), 32'(rsp_error), 32'(vecs[i-RD_LAT].e_re));
            end else begin
                check_output($sformatf("step%0d rsp_valid", i), 32'(rsp_valid), 32'h0);
            end
        end

        // Read accepted, then reset the following cycle: the in-flight response must vanish.
        apply_stimulus('{2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0,
                         2'b00, 1'b1, 1'b0, 18'h4, 32'h0, 4'h0, 2'b01, 32'hDEADBEEF, 2'b00});
        @(negedge clk);
        check_output("flush accept cs", 32'(sram_cs), 32'h1);
        check_output("flush accept hold", 32'(req_hold), 32'h0);
        @(posedge clk);
        #1;
        req_dv = 2'b00;
        rst    = 1'b1;
        @(negedge clk);
        check_output("flush during rst rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_output($sformatf("flush after rst rsp_valid c%0d", c), 32'(rsp_valid), 32'h0);
        end

        // Continuous contention from a fresh rr_ptr: req0 first, then strict alternation.
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 8 + RD_LAT; k++) begin
            @(posedge clk);
            #1;
            req_write    = 2'b00;
            req_addr[0]  = 32'h10;
            req_addr[1]  = 32'h20;
            req_dv       = (k < 8) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (k < 8) begin
                check_output($sformatf("contend k%0d hold", k), 32'(req_hold), (k % 2 == 0) ? 32'h2 : 32'h1);
            end
            exp_rv = 2'b00;
            if (k >= RD_LAT && k - RD_LAT < 8) exp_rv = ((k - RD_LAT) % 2 == 0) ? 2'b01 : 2'b10;
            check_output($sformatf("contend k%0d rsp_valid", k), 32'(rsp_valid), 32'(exp_rv));
            if (rsp_valid[0]) begin
                cnt0++;
                check_output($sformatf("contend k%0d rdata0", k), rsp_rdata, 32'hDEADBEEF);
            end
            if (rsp_valid[1]) begin
                cnt1++;
                check_output($sformatf("contend k%0d rdata1", k), rsp_rdata, 32'hFF22FF44);
            end
        end
        check_output("contend count req0", 32'(cnt0), 32'd4);
        check_output("contend count req1", 32'(cnt1), 32'd4);

        drive_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
